// File: rtl/avg_unpool_layer_if.sv
// Handshake and data bundle for avg_unpool_layer: start/busy/done plus the input map and the upsampled output map.
interface avg_unpool_layer_if #(
    parameter int IN_DIM = 5
);
    logic        start;
    logic [31:0] ImageIn  [IN_DIM][IN_DIM];
    logic [31:0] ImageOut [2*IN_DIM][2*IN_DIM];
    logic        busy;
    logic        done;

    modport master (
        output start,
        output ImageIn,
        input  ImageOut,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  ImageIn,
        output ImageOut,
        output busy,
        output done
    );
endinterface

// File: rtl/avg_unpool_layer.sv
// 2x2 unpooling of an IN_DIM x IN_DIM float map: each element is replicated into a 2x2 output block, one element per cycle.
// Define AVG_UNPOOL_SCALE_EN to divide each replicated value by 4 (average-pool backward pass); otherwise plain replication.
module avg_unpool_layer #(
    parameter int IN_DIM = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    avg_unpool_layer_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; captures ImageIn when start is seen
    // RUN   | writes one buffered element per cycle, raster order
    // DONE  | single-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM = IN_DIM * IN_DIM;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int RW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM - 1);
    localparam logic [RW-1:0] LAST_COL = RW'(IN_DIM - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_buf [IN_DIM][IN_DIM];
    logic [31:0] r_out [2*IN_DIM][2*IN_DIM];
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_col;
    logic        w_last;
    logic        w_load;
    logic        w_step;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_val;

    // Exact divide-by-4 on the float fields; subnormal results are truncated, never rounded.
    function automatic logic [31:0] f_scale(input logic [31:0] y);
`ifdef AVG_UNPOOL_SCALE_EN
        logic [7:0]  exp_in;
        logic [22:0] man_in;
        exp_in = y[30:23];
        man_in = y[22:0];
        if (exp_in == 8'hFF)
            return y;
        else if (exp_in >= 8'd3)
            return {y[31], exp_in - 8'd2, man_in};
        else if (exp_in == 8'd2)
            return {y[31], 8'd0, 1'b1, man_in[22:1]};
        else if (exp_in == 8'd1)
            return {y[31], 8'd0, 2'b01, man_in[22:2]};
        else
            return {y[31], 8'd0, 2'b00, man_in[22:2]};
`else
        return y;
`endif
    endfunction

    assign w_last = (r_cnt == LAST_IDX);
    assign w_val  = f_scale(r_buf[r_row][r_col]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE:    w_load = bus.start;
            RUN: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Output map is only cleared by reset; a new frame overwrites it block by block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IN_DIM; r++)
                for (int c = 0; c < IN_DIM; c++)
                    r_buf[r][c] <= '0;
            for (int r = 0; r < 2*IN_DIM; r++)
                for (int c = 0; c < 2*IN_DIM; c++)
                    r_out[r][c] <= '0;
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_load) begin
            r_buf <= bus.ImageIn;
            r_cnt <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_step) begin
            r_out[{r_row, 1'b0}][{r_col, 1'b0}] <= w_val;
            r_out[{r_row, 1'b0}][{r_col, 1'b1}] <= w_val;
            r_out[{r_row, 1'b1}][{r_col, 1'b0}] <= w_val;
            r_out[{r_row, 1'b1}][{r_col, 1'b1}] <= w_val;
            r_cnt <= r_cnt + 1'b1;
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign bus.ImageOut = r_out;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
endmodule
